// File: rtl/dncounter_seq_if.sv
// Control/status bundle between convolution control logic and the down-counter sequencer.
interface dncounter_seq_if #(
  parameter int CNT_WIDTH  = 3,
  parameter int PASS_WIDTH = 4
);
  // Handshake: cnt_start is a single-cycle request with no ready; the requester
  // watches cnt_busy (RUN), cnt_done (pass finished) and cnt_err (start refused).
  logic                  cnt_start;
  logic                  cnt_en;
  logic                  cnt_ld_en;
  logic [CNT_WIDTH-1:0]  cnt_ld_val;
  logic [CNT_WIDTH-1:0]  cnt_downto;
  logic                  cnt_reload;
  logic                  cnt_abort;
  logic [CNT_WIDTH-1:0]  cnt_out;
  logic                  cnt_busy;
  logic                  cnt_done;
  logic                  cnt_err;
  logic [PASS_WIDTH-1:0] cnt_pass;
  logic                  cnt_state;

  modport master (
    output cnt_start, cnt_en, cnt_ld_en, cnt_ld_val, cnt_downto, cnt_reload, cnt_abort,
    input  cnt_out, cnt_busy, cnt_done, cnt_err, cnt_pass, cnt_state
  );

  modport slave (
    input  cnt_start, cnt_en, cnt_ld_en, cnt_ld_val, cnt_downto, cnt_reload, cnt_abort,
    output cnt_out, cnt_busy, cnt_done, cnt_err, cnt_pass, cnt_state
  );
endinterface

// File: rtl/dncounter_seq.sv
// Loadable down-counter sequencer: counts a latched top value down to a floor,
// optionally auto-reloading, with done/err pulses and a saturating pass count.
module dncounter_seq #(
  parameter int CNT_WIDTH  = 3,
  parameter int PASS_WIDTH = 4
) (
  input logic          cnt_clk,
  input logic          cnt_rst,
  dncounter_seq_if.slave bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [PASS_WIDTH-1:0] PASS_ONE = PASS_WIDTH'(1);
  localparam logic [PASS_WIDTH-1:0] PASS_MAX = '1;

  logic [0:0]            state;
  logic [CNT_WIDTH-1:0]  top;
  logic [CNT_WIDTH-1:0]  floor_val;
  logic                  mode_reload;
  logic [CNT_WIDTH-1:0]  count;
  logic                  done;
  logic                  err;
  logic [PASS_WIDTH-1:0] pass;

  always_ff @(posedge cnt_clk or posedge cnt_rst) begin
    if (cnt_rst) begin
      state       <= ST_IDLE;
      top         <= '0;
      floor_val   <= '0;
      mode_reload <= 1'b0;
      count       <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      pass        <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (bus.cnt_abort) begin
        state <= ST_IDLE;
      end else if (bus.cnt_start) begin
        // A refused start never disturbs count or pass; from RUN it also stops the walk.
        if (bus.cnt_ld_val >= bus.cnt_downto) begin
          top         <= bus.cnt_ld_val;
          floor_val   <= bus.cnt_downto;
          mode_reload <= bus.cnt_reload;
          count       <= bus.cnt_ld_val;
          pass        <= '0;
          state       <= ST_RUN;
        end else begin
          err   <= 1'b1;
          state <= ST_IDLE;
        end
      end else if (state == ST_RUN) begin
        if (bus.cnt_ld_en) begin
          count <= top;
        end else if (bus.cnt_en) begin
          if (count > floor_val) begin
            count <= count - CNT_ONE;
          end else begin
            // count never drops below the floor, so this branch is the terminal step.
            done <= 1'b1;
            if (pass != PASS_MAX) pass <= pass + PASS_ONE;
            if (mode_reload) count <= top;
            else             state <= ST_IDLE;
          end
        end
      end
    end
  end

  assign bus.cnt_out   = count;
  assign bus.cnt_busy  = (state == ST_RUN);
  assign bus.cnt_done  = done;
  assign bus.cnt_err   = err;
  assign bus.cnt_pass  = pass;
  assign bus.cnt_state = state[0];

endmodule

// File: tb/tb_dncounter_seq.sv
// Directed bench for dncounter_seq: vector table for the main sequences plus
// hand-written runs for saturation and asynchronous reset.
module tb_dncounter_seq;
  localparam int CW = 3;
  localparam int PW = 2;

  typedef struct {
    logic          st, en, ld;
    logic [CW-1:0] val, dn;
    logic          rl, ab;
    logic [CW-1:0] e_out;
    logic          e_busy, e_done, e_err;
    logic [PW-1:0] e_pass;
  } vec_t;

  logic cnt_clk = 1'b0;
  logic cnt_rst = 1'b1;
  int   checks  = 0;
  int   errors  = 0;
  vec_t vecs[$];
  logic [CW-1:0] exp_q[$];

  dncounter_seq_if #(.CNT_WIDTH(CW), .PASS_WIDTH(PW)) bus ();

  dncounter_seq #(.CNT_WIDTH(CW), .PASS_WIDTH(PW)) dut (
    .cnt_clk (cnt_clk),
    .cnt_rst (cnt_rst),
    .bus     (bus)
  );

  // clock / watchdog
  always #5 cnt_clk = ~cnt_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(input logic st, en, ld, input int val, dn, input logic rl, ab,
                              input int e_out, input logic e_busy, e_done, e_err, input int e_pass);
    vec_t v;
    v.st = st; v.en = en; v.ld = ld;
    v.val = CW'(val); v.dn = CW'(dn); v.rl = rl; v.ab = ab;
    v.e_out = CW'(e_out); v.e_busy = e_busy; v.e_done = e_done; v.e_err = e_err;
    v.e_pass = PW'(e_pass);
    return v;
  endfunction

  task automatic drive(input logic st, en, ld, input logic [CW-1:0] val, dn, input logic rl, ab);
    bus.cnt_start  = st;
    bus.cnt_en     = en;
    bus.cnt_ld_en  = ld;
    bus.cnt_ld_val = val;
    bus.cnt_downto = dn;
    bus.cnt_reload = rl;
    bus.cnt_abort  = ab;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int e_out, input logic e_busy, e_done, e_err,
                           input int e_pass);
    check({tag, " out"},  int'(bus.cnt_out),  e_out);
    check({tag, " busy"}, int'(bus.cnt_busy), int'(e_busy));
    check({tag, " done"}, int'(bus.cnt_done), int'(e_done));
    check({tag, " err"},  int'(bus.cnt_err),  int'(e_err));
    check({tag, " pass"}, int'(bus.cnt_pass), e_pass);
  endtask

  task automatic step_check(input vec_t v, input string tag);
    drive(v.st, v.en, v.ld, v.val, v.dn, v.rl, v.ab);
    @(posedge cnt_clk);
    #1;
    check_all(tag, int'(v.e_out), v.e_busy, v.e_done, v.e_err, int'(v.e_pass));
  endtask

  initial begin
    // test 1: plain countdown 5..1, no reload
    vecs.push_back(mk(1,1,0, 5,1,0,0, 5,1,0,0,0));
    vecs.push_back(mk(0,1,0, 0,0,0,0, 4,1,0,0,0));
    vecs.push_back(mk(0,1,0, 0,0,0,0, 3,1,0,0,0));
    vecs.push_back(mk(0,1,0, 0,0,0,0, 2,1,0,0,0));
    vecs.push_back(mk(0,1,0, 0,0,0,0, 1,1,0,0,0));
    vecs.push_back(mk(0,1,0, 0,0,0,0, 1,0,1,0,1));
    vecs.push_back(mk(0,1,0, 0,0,0,0, 1,0,0,0,1));
    // test 2: reload 5..2, 12 enabled cycles
    vecs.push_back(mk(1,1,0, 5,2,1,0, 5,1,0,0,0));
    vecs.push_back(mk(0,1,0, 0,0,0,0, 4,1,0,0,0));
    vecs.push_back(mk(0,1,0, 0,0,0,0, 3,1,0,0,0));
    vecs.push_back(mk(0,1,0, 0,0,0,0, 2,1,0,0,0));
    vecs.push_back(mk(0,1,0, 0,0,0,0, 5,1,1,0,1));
    vecs.push_back(mk(0,1,0, 0,0,0,0, 4,1,0,0,1));
    vecs.push_back(mk(0,1,0, 0,0,0,0, 3,1,0,0,1));
    vecs.push_back(mk(0,1,0, 0,0,0,0, 2,1,0,0,1));
    vecs.push_back(mk(0,1,0, 0,0,0,0, 5,1,1,0,2));
    vecs.push_back(mk(0,1,0, 0,0,0,0, 4,1,0,0,2));
    vecs.push_back(mk(0,1,0, 0,0,0,0, 3,1,0,0,2));
    vecs.push_back(mk(0,1,0, 0,0,0,0, 2,1,0,0,2));
    vecs.push_back(mk(0,1,0, 0,0,0,0, 5,1,1,0,3));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 5,1,0,0,3));
    // test 3: abort, then illegal start from IDLE
    vecs.push_back(mk(0,1,0, 0,0,0,1, 5,0,0,0,3));
    vecs.push_back(mk(1,1,0, 1,3,0,0, 5,0,0,1,3));
    vecs.push_back(mk(0,1,0, 0,0,0,0, 5,0,0,0,3));
    // test 4: load beats enable, abort beats enable
    vecs.push_back(mk(1,1,0, 5,1,0,0, 5,1,0,0,0));
    vecs.push_back(mk(0,1,0, 0,0,0,0, 4,1,0,0,0));
    vecs.push_back(mk(0,1,0, 0,0,0,0, 3,1,0,0,0));
    vecs.push_back(mk(0,1,1, 0,0,0,0, 5,1,0,0,0));
    vecs.push_back(mk(0,1,0, 0,0,0,0, 4,1,0,0,0));
    vecs.push_back(mk(0,1,0, 0,0,0,1, 4,0,0,0,0));
    vecs.push_back(mk(0,1,0, 0,0,0,0, 4,0,0,0,0));
    // illegal restart while running
    vecs.push_back(mk(1,0,0, 5,0,0,0, 5,1,0,0,0));
    vecs.push_back(mk(1,1,0, 2,4,0,0, 5,0,0,1,0));
    // top == floor with reload: consecutive done pulses
    vecs.push_back(mk(1,0,0, 3,3,1,0, 3,1,0,0,0));
    vecs.push_back(mk(0,1,0, 0,0,0,0, 3,1,1,0,1));
    vecs.push_back(mk(0,1,0, 0,0,0,0, 3,1,1,0,2));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 3,1,0,0,2));
    vecs.push_back(mk(0,0,0, 0,0,0,1, 3,0,0,0,2));

    drive(0, 0, 0, '0, '0, 0, 0);
    #1;
    check_all("reset", 0, 0, 0, 0, 0);
    @(negedge cnt_clk);
    cnt_rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) step_check(vecs[i], $sformatf("vec%0d", i));

    // test 5: 7..0 reload, pass saturates at 3
    step_check(mk(1,1,0, 7,0,1,0, 7,1,0,0,0), "sat start");
    for (int i = 1; i <= 40; i++) exp_q.push_back(CW'(7 - (i % 8)));
    for (int i = 1; i <= 40; i++) begin
      drive(0, 1, 0, '0, '0, 0, 0);
      @(posedge cnt_clk);
      #1;
      check($sformatf("sat out%0d", i), int'(bus.cnt_out), int'(exp_q.pop_front()));
      check($sformatf("sat done%0d", i), int'(bus.cnt_done), (i % 8 == 0) ? 1 : 0);
      check($sformatf("sat pass%0d", i), int'(bus.cnt_pass), (i / 8 > 3) ? 3 : i / 8);
    end
    check("sat busy", int'(bus.cnt_busy), 1);

    // test 6: asynchronous reset mid-RUN at count 4 with nonzero pass
    step_check(mk(1,0,0, 5,4,1,0, 5,1,0,0,0), "ar start");
    step_check(mk(0,1,0, 0,0,0,0, 4,1,0,0,0), "ar s1");
    step_check(mk(0,1,0, 0,0,0,0, 5,1,1,0,1), "ar s2");
    step_check(mk(0,1,0, 0,0,0,0, 4,1,0,0,1), "ar s3");
    #3;
    cnt_rst = 1'b1;
    #1;
    check_all("async rst", 0, 0, 0, 0, 0);
    @(negedge cnt_clk);
    cnt_rst = 1'b0;
    for (int i = 0; i < 3; i++) step_check(mk(0,1,0, 0,0,0,0, 0,0,0,0,0), $sformatf("post rst%0d", i));
    step_check(mk(1,1,0, 6,2,0,0, 6,1,0,0,0), "post rst start");
    step_check(mk(0,1,0, 0,0,0,0, 5,1,0,0,0), "post rst step");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
